// File: rtl/masked_add_seq.sv
// Bit-serial first-order masked adder: sums two share-split W-bit operands one bit per step.
// Latency: W+1 cycles from accept to out_valid when rnd_valid is held high; +1 per rnd stall cycle.
// Backpressure: in_ready only in IDLE; a step waits on rnd_valid; result held in DONE until out_ready.
//
// Ports:
//   i_clk, i_rst                   clock (rising edge), synchronous active-high reset
//   i_in_valid / o_in_ready        operand handshake; i_a0^i_a1 = A, i_b0^i_b1 = B
//   i_rnd_valid / o_rnd_ready      randomness handshake; i_rnd[0] = r_g, i_rnd[1] = r_t
//   o_out_valid / i_out_ready      result handshake; o_s0^o_s1 = (A+B) mod 2^W
//   o_co0, o_co1                   carry-out shares of bit W-1
//   o_busy                         high while running or holding a result
module masked_add_seq #(
  parameter int W           = 8,
  parameter bit CLR_ON_DONE = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_a0,
  input  logic [W-1:0] i_a1,
  input  logic [W-1:0] i_b0,
  input  logic [W-1:0] i_b1,
  input  logic         i_rnd_valid,
  output logic         o_rnd_ready,
  input  logic [1:0]   i_rnd,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_s0,
  output logic [W-1:0] o_s1,
  output logic         o_co0,
  output logic         o_co1,
  output logic         o_busy
);

  localparam int            IW   = $clog2(W);
  localparam logic [IW-1:0] LAST = IW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;
  logic          w_step;
  logic          w_handoff;

  logic [W-1:0]  r_a0, r_a1, r_b0, r_b1;
  logic [W-1:0]  r_s0, r_s1;
  logic          r_c0, r_c1;
  logic [IW-1:0] r_idx;

  logic          w_x0, w_x1, w_y0, w_y1;
  logic          w_p0, w_p1;
  logic          w_g0, w_g1, w_t0, w_t1;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_rnd_ready = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_handoff   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        o_busy      = 1'b1;
        o_rnd_ready = 1'b1;
        // One rnd handshake is exactly one step; no rnd means a full stall.
        if (i_rnd_valid) begin
          w_step = 1'b1;
          if (r_idx == LAST) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        // in_ready stays low here, so the handoff cycle never doubles as an accept.
        if (i_out_ready) begin
          w_handoff   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Share pairs of the current bit position.
  assign w_x0 = r_a0[r_idx];
  assign w_x1 = r_a1[r_idx];
  assign w_y0 = r_b0[r_idx];
  assign w_y1 = r_b1[r_idx];

  assign w_p0 = w_x0 ^ w_y0;
  assign w_p1 = w_x1 ^ w_y1;

  // Masked ANDs: each output share mixes in the fresh bit so neither share alone
  // carries x&y (or c&p); the two copies of the fresh bit cancel on recombination.
  assign w_g0 = (w_x0 & w_y0) ^ (w_x0 & w_y1) ^ i_rnd[0];
  assign w_g1 = (w_x1 & w_y1) ^ (w_x1 & w_y0) ^ i_rnd[0];
  assign w_t0 = (r_c0 & w_p0) ^ (r_c0 & w_p1) ^ i_rnd[1];
  assign w_t1 = (r_c1 & w_p1) ^ (r_c1 & w_p0) ^ i_rnd[1];

  // g and t are never both 1 in the unmasked domain, so XOR equals the OR of a ripple carry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a0  <= '0;
      r_a1  <= '0;
      r_b0  <= '0;
      r_b1  <= '0;
      r_s0  <= '0;
      r_s1  <= '0;
      r_c0  <= 1'b0;
      r_c1  <= 1'b0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_a0  <= i_a0;
      r_a1  <= i_a1;
      r_b0  <= i_b0;
      r_b1  <= i_b1;
      r_s0  <= '0;
      r_s1  <= '0;
      r_c0  <= 1'b0;
      r_c1  <= 1'b0;
      r_idx <= '0;
    end else if (w_step) begin
      r_s0[r_idx] <= w_p0 ^ r_c0;
      r_s1[r_idx] <= w_p1 ^ r_c1;
      r_c0        <= w_g0 ^ w_t0;
      r_c1        <= w_g1 ^ w_t1;
      r_idx       <= (r_idx == LAST) ? '0 : r_idx + IW'(1);
    end else if (w_handoff && CLR_ON_DONE) begin
      r_a0 <= '0;
      r_a1 <= '0;
      r_b0 <= '0;
      r_b1 <= '0;
      r_s0 <= '0;
      r_s1 <= '0;
      r_c0 <= 1'b0;
      r_c1 <= 1'b0;
    end
  end

  assign o_s0  = r_s0;
  assign o_s1  = r_s1;
  assign o_co0 = r_c0;
  assign o_co1 = r_c1;

endmodule

// File: tb/tb_masked_add_seq.sv
// Directed bench for masked_add_seq (W=8, CLR_ON_DONE=1) with hand-computed sums.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
// Ends with one summary line of check and error counts.
module tb_masked_add_seq;

  logic       i_clk;
  logic       i_rst;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [7:0] i_a0, i_a1, i_b0, i_b1;
  logic       i_rnd_valid;
  logic       o_rnd_ready;
  logic [1:0] i_rnd;
  logic       o_out_valid;
  logic       i_out_ready;
  logic [7:0] o_s0, o_s1;
  logic       o_co0, o_co1;
  logic       o_busy;

  int n_checks = 0;
  int n_errors = 0;

  masked_add_seq #(.W(8), .CLR_ON_DONE(1'b1)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_a0        (i_a0),
    .i_a1        (i_a1),
    .i_b0        (i_b0),
    .i_b1        (i_b1),
    .i_rnd_valid (i_rnd_valid),
    .o_rnd_ready (o_rnd_ready),
    .i_rnd       (i_rnd),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_s0        (o_s0),
    .o_s1        (o_s1),
    .o_co0       (o_co0),
    .o_co1       (o_co1),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Runs one operation up to out_valid and leaves the result pending.
  // rnd_mode 0: fresh random rnd each cycle; 1: rnd fixed at rfix.
  // stall: rnd_valid follows 1,0,0,1,0,0,... while running.
  // lat counts rising edges from the accept edge (inclusive) to the edge after which out_valid is seen.
  task automatic do_op(input logic [7:0] a0, a1, b0, b1, input int rnd_mode, input logic [1:0] rfix,
                       input bit stall, output logic [7:0] s0, s1, output logic co0, co1,
                       output int lat, output int stalls);
    int  k;
    bit  seen;
    int  guard;
    lat    = 0;
    stalls = 0;
    k      = 0;
    seen   = 0;
    s0 = '0; s1 = '0; co0 = 1'b0; co1 = 1'b0;
    guard = 0;
    while (!o_in_ready && guard < 50) begin
      @(posedge i_clk); #1;
      guard++;
    end
    i_a0 = a0; i_a1 = a1; i_b0 = b0; i_b1 = b1;
    i_in_valid  = 1'b1;
    i_rnd_valid = 1'b1;
    i_rnd = (rnd_mode == 0) ? 2'($urandom_range(0, 3)) : rfix;
    for (int c = 0; c < 300; c++) begin
      @(posedge i_clk); #1;
      i_in_valid = 1'b0;
      lat++;
      if (o_out_valid) begin
        seen = 1;
        break;
      end
      i_rnd_valid = stall ? ((k % 3) == 0) : 1'b1;
      if (!i_rnd_valid) stalls++;
      k++;
      i_rnd = (rnd_mode == 0) ? 2'($urandom_range(0, 3)) : rfix;
    end
    if (!seen) chk("out_valid_timeout", 32'(seen), 32'd1);
    s0 = o_s0; s1 = o_s1; co0 = o_co0; co1 = o_co1;
    i_rnd_valid = 1'b1;
  endtask

  task automatic release_out();
    i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    i_out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] s0, s1, fs0, fs1;
    logic       co0, co1, fco0, fco1;
    int         lat, stalls;
    logic [7:0] a, b, ra, rb, first_s0;
    logic [8:0] ref_sum;
    bit         s0_varies;

    i_rst = 1'b1; i_in_valid = 1'b0; i_out_ready = 1'b0;
    i_a0 = '0; i_a1 = '0; i_b0 = '0; i_b1 = '0;
    i_rnd_valid = 1'b0; i_rnd = 2'b00;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_in_ready",  32'(o_in_ready),  32'd1);
    chk("rst_rnd_ready", 32'(o_rnd_ready), 32'd0);
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_busy",      32'(o_busy),      32'd0);
    chk("rst_s",         {16'h0, o_s0, o_s1}, 32'h0);
    i_rst = 1'b0;

    // A=0x5A, B=0x33 -> 0x8D, no carry, out_valid 9 cycles after the accept cycle
    do_op(8'h3C, 8'h66, 8'h0F, 8'h3C, 0, 2'b00, 0, s0, s1, co0, co1, lat, stalls);
    chk("basic_sum",  32'(s0 ^ s1),   32'h8D);
    chk("basic_co",   32'(co0 ^ co1), 32'd0);
    chk("basic_lat",  32'(lat),       32'd9);
    chk("done_busy",  32'(o_busy),    32'd1);
    chk("done_in_rdy",32'(o_in_ready),32'd0);
    chk("done_rnd_rdy",32'(o_rnd_ready),32'd0);
    release_out();
    chk("clr_s",      {16'h0, o_s0, o_s1}, 32'h0);
    chk("clr_in_rdy", 32'(o_in_ready), 32'd1);

    // A=0xFF, B=0x01 -> 0x00 with carry, for random, all-zero and all-one rnd
    for (int m = 0; m < 3; m++) begin
      do_op(8'hA5, 8'h5A, 8'h77, 8'h76, (m == 0) ? 0 : 1, (m == 1) ? 2'b00 : 2'b11, 0,
            s0, s1, co0, co1, lat, stalls);
      chk("wrap_sum", 32'(s0 ^ s1),   32'h00);
      chk("wrap_co",  32'(co0 ^ co1), 32'd1);
      release_out();
    end

    // Stalled rnd: 8 steps spaced 3 cycles apart -> 14 stall cycles, latency 9+14
    do_op(8'h3C, 8'h66, 8'h0F, 8'h3C, 0, 2'b00, 1, s0, s1, co0, co1, lat, stalls);
    chk("stall_sum",   32'(s0 ^ s1), 32'h8D);
    chk("stall_co",    32'(co0 ^ co1), 32'd0);
    chk("stall_count", 32'(stalls),  32'd14);
    chk("stall_lat",   32'(lat),     32'd23);
    release_out();

    // Hold in DONE for 5 cycles with a competing in_valid: A=0x12, B=0x34 -> 0x46
    do_op(8'h10, 8'h02, 8'h30, 8'h04, 0, 2'b00, 0, fs0, fs1, fco0, fco1, lat, stalls);
    chk("hold_sum", 32'(fs0 ^ fs1), 32'h46);
    i_a0 = 8'hFF; i_a1 = 8'h00; i_b0 = 8'hFF; i_b1 = 8'h00;
    i_in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clk); #1;
      chk("hold_s",      {16'h0, o_s0, o_s1}, {16'h0, fs0, fs1});
      chk("hold_co",     {30'h0, o_co0, o_co1}, {30'h0, fco0, fco1});
      chk("hold_vld",    32'(o_out_valid), 32'd1);
      chk("hold_in_rdy", 32'(o_in_ready),  32'd0);
    end
    // in_valid still high across the handoff edge: must not be taken
    release_out();
    i_in_valid = 1'b0;
    chk("handoff_busy",   32'(o_busy),      32'd0);
    chk("handoff_vld",    32'(o_out_valid), 32'd0);
    chk("handoff_in_rdy", 32'(o_in_ready),  32'd1);
    chk("handoff_clr",    {14'h0, o_co0, o_co1, o_s0, o_s1}, 32'h0);

    // Reset at idx=4 aborts the run
    i_a0 = 8'h3C; i_a1 = 8'h66; i_b0 = 8'h0F; i_b1 = 8'h3C;
    i_in_valid = 1'b1; i_rnd_valid = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    repeat (4) begin
      i_rnd = 2'($urandom_range(0, 3));
      @(posedge i_clk); #1;
    end
    chk("abort_busy_before", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("abort_in_rdy",  32'(o_in_ready),  32'd1);
    chk("abort_vld",     32'(o_out_valid), 32'd0);
    chk("abort_rnd_rdy", 32'(o_rnd_ready), 32'd0);
    chk("abort_s",       {16'h0, o_s0, o_s1}, 32'h0);
    // A=0x01, B=0x02 -> 0x03 after the abort
    do_op(8'h81, 8'h80, 8'hC3, 8'hC1, 0, 2'b00, 0, s0, s1, co0, co1, lat, stalls);
    chk("post_abort_sum", 32'(s0 ^ s1),   32'h03);
    chk("post_abort_co",  32'(co0 ^ co1), 32'd0);
    release_out();

    // Random vectors against (A+B) mod 256 with carry
    for (int v = 0; v < 1000; v++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ref_sum = {1'b0, a} + {1'b0, b};
      do_op(ra, a ^ ra, rb, b ^ rb, 0, 2'b00, 0, s0, s1, co0, co1, lat, stalls);
      chk("rand_sum", 32'(s0 ^ s1),   32'(ref_sum[7:0]));
      chk("rand_co",  32'(co0 ^ co1), 32'(ref_sum[8]));
      release_out();
    end

    // s0 alone must depend on the share split for fixed A=0x5A, B=0x33
    s0_varies = 0;
    first_s0  = '0;
    for (int v = 0; v < 16; v++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      do_op(ra, 8'h5A ^ ra, rb, 8'h33 ^ rb, 0, 2'b00, 0, s0, s1, co0, co1, lat, stalls);
      if (v == 0) first_s0 = s0;
      else if (s0 != first_s0) s0_varies = 1;
      release_out();
    end
    chk("s0_not_constant", 32'(s0_varies), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
